// File: rtl/alu_result_buffer.sv
// FIFO buffer for ALU results, carrying the opcode tag and zero/negative flags per entry.
// Optional macro ALU_RES_PARITY_EN adds an out_parity output (XOR of the head result).
module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op,
    output logic             out_zero,
    output logic             out_neg,
`ifdef ALU_RES_PARITY_EN
    output logic             out_parity,
`endif
    output logic [4:0]       level,
    output logic [15:0]      accept_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] LVL_FULL = 5'(DEPTH);

    function automatic logic calc_zero(input logic [WIDTH-1:0] value);
        return (value == '0);
    endfunction

    function automatic logic calc_neg(input logic [WIDTH-1:0] value);
        return value[WIDTH-1];
    endfunction

`ifdef ALU_RES_PARITY_EN
    function automatic logic calc_parity(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction
`endif

    logic [WIDTH-1:0] res_mem  [DEPTH];
    logic [2:0]       op_mem   [DEPTH];
    logic [DEPTH-1:0] zero_mem;
    logic [DEPTH-1:0] neg_mem;
`ifdef ALU_RES_PARITY_EN
    logic [DEPTH-1:0] par_mem;
`endif

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Handshake depends on registered occupancy only.
    assign in_ready  = (level != LVL_FULL);
    assign out_valid = (level != 5'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= 5'd0;
            accept_cnt <= 16'd0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                accept_cnt <= accept_cnt + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 5'd1;
            end else if (pop && !push) begin
                level <= level - 5'd1;
            end
        end
    end

    // Entry storage holds data only; validity is tracked by level, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr]  <= in_result;
            op_mem[wr_ptr]   <= in_op;
            zero_mem[wr_ptr] <= calc_zero(in_result);
            neg_mem[wr_ptr]  <= calc_neg(in_result);
`ifdef ALU_RES_PARITY_EN
            par_mem[wr_ptr]  <= calc_parity(in_result);
`endif
        end
    end

    // Gating by out_valid keeps the head outputs at 0 while the buffer is empty.
    assign out_result = out_valid ? res_mem[rd_ptr] : '0;
    assign out_op     = out_valid ? op_mem[rd_ptr] : 3'd0;
    assign out_zero   = out_valid & zero_mem[rd_ptr];
    assign out_neg    = out_valid & neg_mem[rd_ptr];
`ifdef ALU_RES_PARITY_EN
    assign out_parity = out_valid & par_mem[rd_ptr];
`endif

endmodule
